// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer.
// Holds the FSM state type, the frame opcodes and the EXEC timeout length.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_A,
      GET_B,
      GET_FUN,
      EXEC,
      SEND,
      GAP
   } state_t;

   localparam logic [7:0] CMD_FULL  = 8'hCC;
   localparam logic [7:0] CMD_REUSE = 8'hDD;

   localparam int EXEC_TIMEOUT = 4;

endpackage

// File: rtl/alu_cmd_sequencer_result_serializer.sv
// Shifts a captured ALU result out LSB byte first, one strobe per free transmitter slot,
// with a guard cycle after every strobe so the transmitter has time to raise tx_busy.
module result_serializer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int RESULT_W = 16
) (
   input  logic                clk,
   input  logic                RST,
   input  logic [RESULT_W-1:0] result,
   input  logic                load,
   input  logic                tx_busy,
   output logic [DATA_W-1:0]   tx_data,
   output logic                tx_valid,
   output logic                done
);

   localparam int NBYTES = RESULT_W / DATA_W;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   logic [RESULT_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                active_q, active_d;
   logic                gap_q, gap_d;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         shift_q  <= '0;
         idx_q    <= '0;
         active_q <= 1'b0;
         gap_q    <= 1'b0;
      end else begin
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         active_q <= active_d;
         gap_q    <= gap_d;
      end
   end

   // The current byte always sits in the low lane; each strobe shifts the next one down.
   always_comb begin
      tx_valid = active_q && !gap_q && !tx_busy;
      tx_data  = tx_valid ? shift_q[DATA_W-1:0] : '0;
      done     = tx_valid && (idx_q == IDX_LAST);

      shift_d  = shift_q;
      idx_d    = idx_q;
      active_d = active_q;
      gap_d    = gap_q;

      if (load) begin
         shift_d  = result;
         idx_d    = '0;
         active_d = 1'b1;
         gap_d    = 1'b0;
      end else if (tx_valid) begin
         shift_d  = shift_q >> DATA_W;
         idx_d    = idx_q + 1'b1;
         gap_d    = !done;
         active_d = !done;
      end else if (gap_q) begin
         gap_d = 1'b0;
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Parses CMD_FULL / CMD_REUSE byte frames, drives the ALU operands and enable,
// and hands the captured result to the serializer for transmission.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OPERAND_W = 16,
   parameter int RESULT_W  = 16
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic [DATA_W-1:0]    rx_data,
   input  logic                 rx_valid,
   output logic [OPERAND_W-1:0] alu_a,
   output logic [OPERAND_W-1:0] alu_b,
   output logic [3:0]           alu_fun,
   output logic                 alu_en,
   input  logic [RESULT_W-1:0]  alu_out,
   input  logic                 alu_valid,
   output logic [DATA_W-1:0]    tx_data,
   output logic                 tx_valid,
   input  logic                 tx_busy,
   output logic                 busy,
   output logic                 err
);

   localparam int OP_BYTES = OPERAND_W / DATA_W;
   localparam int CNT_MAX  = (OP_BYTES > EXEC_TIMEOUT) ? OP_BYTES : EXEC_TIMEOUT;
   localparam int CNT_W    = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_BYTES - 1);
   localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 full_q, full_d;
   logic [OPERAND_W-1:0] shadow_a_q, shadow_a_d;
   logic [OPERAND_W-1:0] shadow_b_q, shadow_b_d;
   logic [OPERAND_W-1:0] alu_a_q, alu_a_d;
   logic [OPERAND_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]           alu_fun_q, alu_fun_d;
   logic                 err_q, err_d;
   logic                 ser_load;
   logic                 ser_done;

   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_fun = alu_fun_q;
   assign alu_en  = (state_q == EXEC);
   assign busy    = (state_q != IDLE);
   assign err     = err_q;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         shadow_a_q <= '0;
         shadow_b_q <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_fun_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         shadow_a_q <= shadow_a_d;
         shadow_b_q <= shadow_b_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_fun_q  <= alu_fun_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      full_d     = full_q;
      shadow_a_d = shadow_a_q;
      shadow_b_d = shadow_b_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_fun_d  = alu_fun_q;
      err_d      = 1'b0;
      ser_load   = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_valid) begin
               if (rx_data == DATA_W'(CMD_FULL)) begin
                  full_d  = 1'b1;
                  state_d = GET_A;
               end else if (rx_data == DATA_W'(CMD_REUSE)) begin
                  full_d  = 1'b0;
                  state_d = GET_FUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         // Operand bytes arrive LSB first, so each new byte enters at the top.
         GET_A: begin
            if (rx_valid) begin
               shadow_a_d = {rx_data, shadow_a_q[OPERAND_W-1:DATA_W]};
               if (cnt_q == OP_LAST) begin
                  cnt_d   = '0;
                  state_d = GET_B;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         GET_B: begin
            if (rx_valid) begin
               shadow_b_d = {rx_data, shadow_b_q[OPERAND_W-1:DATA_W]};
               if (cnt_q == OP_LAST) begin
                  cnt_d   = '0;
                  state_d = GET_FUN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         GET_FUN: begin
            if (rx_valid) begin
               cnt_d = '0;
               if (rx_data[DATA_W-1:4] != '0) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  alu_fun_d = rx_data[3:0];
                  if (full_q) begin
                     alu_a_d = shadow_a_q;
                     alu_b_d = shadow_b_q;
                  end
                  state_d = EXEC;
               end
            end
         end

         // cnt_q counts EXEC cycles; the last allowed one without alu_valid is a timeout.
         EXEC: begin
            if (rx_valid) begin
               err_d = 1'b1;
            end
            if (alu_valid) begin
               ser_load = 1'b1;
               cnt_d    = '0;
               state_d  = SEND;
            end else if (cnt_q == EXEC_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         SEND: begin
            if (rx_valid) begin
               err_d = 1'b1;
            end
            if (ser_done) begin
               state_d = IDLE;
            end else if (tx_valid) begin
               state_d = GAP;
            end
         end

         GAP: begin
            if (rx_valid) begin
               err_d = 1'b1;
            end
            state_d = SEND;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   result_serializer #(
      .DATA_W   (DATA_W),
      .RESULT_W (RESULT_W)
   ) u_serializer (
      .clk      (clk),
      .RST      (RST),
      .result   (alu_out),
      .load     (ser_load),
      .tx_busy  (tx_busy),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .done     (ser_done)
   );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed frames from the test plan plus
// randomized frames, all compared every cycle against a transaction-level model.
module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   localparam int DATA_W    = 8;
   localparam int OPERAND_W = 16;
   localparam int RESULT_W  = 16;
   localparam int RES_BYTES = RESULT_W / DATA_W;

   logic                 clk = 1'b0;
   logic                 RST = 1'b0;
   logic [DATA_W-1:0]    rx_data = '0;
   logic                 rx_valid = 1'b0;
   logic [OPERAND_W-1:0] alu_a;
   logic [OPERAND_W-1:0] alu_b;
   logic [3:0]           alu_fun;
   logic                 alu_en;
   logic [RESULT_W-1:0]  alu_out = '0;
   logic                 alu_valid = 1'b0;
   logic [DATA_W-1:0]    tx_data;
   logic                 tx_valid;
   logic                 tx_busy = 1'b0;
   logic                 busy;
   logic                 err;

   alu_cmd_sequencer #(
      .DATA_W    (DATA_W),
      .OPERAND_W (OPERAND_W),
      .RESULT_W  (RESULT_W)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_fun   (alu_fun),
      .alu_en    (alu_en),
      .alu_out   (alu_out),
      .alu_valid (alu_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_busy   (tx_busy),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Model state: committed operands, expected tx byte stream, expected err/alu_en.
   logic [15:0] ma = '0;
   logic [15:0] mb = '0;
   logic [3:0]  mfun = '0;
   logic [7:0]  exp_q[$];
   bit          exp_err = 1'b0;
   bit          exp_err_pend = 1'b0;
   bit          exp_alu_en = 1'b0;
   bit          armed = 1'b0;
   bit          rand_busy = 1'b0;
   int          hold_from = -100;
   int          last_rx_cyc = 0;

   // Written only by the compare process.
   int          rd_idx = 0;
   int          last_tx_cyc = -100;
   int          en_total = 0;
   int          err_total = 0;
   logic [7:0]  tx_log[$];
   int          tx_cyc_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
      case (f)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return 16'(a * b);
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [31:0] log_byte(input int idx);
      if (idx < tx_log.size()) return 32'(tx_log[idx]);
      return 32'hxxxx_xxxx;
   endfunction

   function automatic int log_cyc(input int idx);
      if (idx < tx_cyc_log.size()) return tx_cyc_log[idx];
      return -1;
   endfunction

   // Transmitter model: optional directed busy window at SEND entry, else random or idle.
   always @(posedge clk) begin
      #1;
      if (cyc >= hold_from && cyc < hold_from + 10) tx_busy = 1'b1;
      else if (rand_busy) tx_busy = ($urandom_range(0, 2) == 0);
      else tx_busy = 1'b0;
   end

   always @(negedge clk) begin
      if (armed) begin
         checkOutput("err", 32'(err), 32'(exp_err));
         checkOutput("alu_en", 32'(alu_en), 32'(exp_alu_en));
         checkOutput("alu_a", 32'(alu_a), 32'(ma));
         checkOutput("alu_b", 32'(alu_b), 32'(mb));
         checkOutput("alu_fun", 32'(alu_fun), 32'(mfun));
         if (alu_en) en_total++;
         if (err) err_total++;
         if (tx_valid) begin
            tx_log.push_back(tx_data);
            tx_cyc_log.push_back(cyc);
            checkOutput("tx_strobe_while_busy", 32'(tx_busy), 32'h0);
            checkOutput("tx_spacing_ge_2", 32'(cyc - last_tx_cyc >= 2), 32'h1);
            last_tx_cyc = cyc;
            if (rd_idx < exp_q.size()) begin
               checkOutput("tx_data", 32'(tx_data), 32'(exp_q[rd_idx]));
               rd_idx++;
            end else begin
               tests++;
               fails++;
               $display("[TB] FAIL tx_unexpected: got byte %0h, expected no strobe (cycle %0d)", tx_data, cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_err = exp_err_pend;
      exp_err_pend = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit offending, input bit gaps);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      rx_data = b;
      rx_valid = 1'b1;
      if (offending) exp_err_pend = 1'b1;
      last_rx_cyc = cyc;
      tick();
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
   endtask

   // lat: cycle of EXEC (1..4) in which alu_valid is returned; 5 means never.
   task automatic runFrame(input bit full, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] funb, input int lat, input bit drop,
                           input bit hold, input bit gaps);
      logic [15:0] res;
      bit          answered;
      if (full) begin
         applyStimulus(CMD_FULL, 1'b0, gaps);
         applyStimulus(a[7:0], 1'b0, gaps);
         applyStimulus(a[15:8], 1'b0, gaps);
         applyStimulus(b[7:0], 1'b0, gaps);
         applyStimulus(b[15:8], 1'b0, gaps);
      end else begin
         applyStimulus(CMD_REUSE, 1'b0, gaps);
      end
      if (funb[7:4] != 4'h0) begin
         applyStimulus(funb, 1'b1, gaps);
      end else begin
         applyStimulus(funb, 1'b0, gaps);
         mfun = funb[3:0];
         if (full) begin
            ma = a;
            mb = b;
         end
         exp_alu_en = 1'b1;
         answered = 1'b0;
         for (int j = 1; j <= 4; j++) begin
            if (!answered) begin
               if (j == lat) begin
                  res = alu_model(ma, mb, mfun);
                  for (int k = 0; k < RES_BYTES; k++) exp_q.push_back(res[k*8 +: 8]);
                  if (hold) hold_from = cyc + 1;
                  alu_out = res;
                  alu_valid = 1'b1;
                  tick();
                  alu_valid = 1'b0;
                  alu_out = 16'($urandom);
                  answered = 1'b1;
               end else begin
                  if (j == 4) exp_err_pend = 1'b1;
                  tick();
               end
            end
         end
         exp_alu_en = 1'b0;
         if (drop && answered) applyStimulus(8'($urandom), 1'b1, 1'b0);
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((rd_idx != exp_q.size() || busy) && n < 300) begin
         tick();
         n++;
      end
      checkOutput("frame_complete", 32'(rd_idx == exp_q.size() && !busy), 32'h1);
      tick();
      tick();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_alu_a"}, 32'(alu_a), 32'h0);
      checkOutput({tag, "_alu_b"}, 32'(alu_b), 32'h0);
      checkOutput({tag, "_alu_fun"}, 32'(alu_fun), 32'h0);
      checkOutput({tag, "_alu_en"}, 32'(alu_en), 32'h0);
      checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'h0);
      checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_err"}, 32'(err), 32'h0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n0, e0, en0, fcyc;
      logic [7:0] badop;

      tick();
      tick();
      @(negedge clk);
      checkResetValues("reset");
      tick();
      RST = 1'b1;
      tick();
      armed = 1'b1;

      // Full command: 5 + 3 -> 08 00, first byte 3 and last byte 5 cycles after FUN.
      n0 = tx_log.size();
      e0 = err_total;
      runFrame(1'b1, 16'd5, 16'd3, 8'h00, 2, 1'b0, 1'b0, 1'b0);
      fcyc = last_rx_cyc;
      waitIdle();
      checkOutput("full_byte0", log_byte(n0), 32'h08);
      checkOutput("full_byte1", log_byte(n0 + 1), 32'h00);
      checkOutput("full_first_latency", 32'(log_cyc(n0) - fcyc), 32'd3);
      checkOutput("full_last_latency", 32'(log_cyc(n0 + 1) - fcyc), 32'd5);
      checkOutput("full_alu_a", 32'(alu_a), 32'd5);
      checkOutput("full_alu_b", 32'(alu_b), 32'd3);
      checkOutput("full_no_err", 32'(err_total - e0), 32'd0);

      // Reuse with FUN 2: 5 * 3 -> 0F 00.
      n0 = tx_log.size();
      runFrame(1'b0, 16'd0, 16'd0, 8'h02, 2, 1'b0, 1'b0, 1'b0);
      waitIdle();
      checkOutput("reuse_byte0", log_byte(n0), 32'h0F);
      checkOutput("reuse_byte1", log_byte(n0 + 1), 32'h00);
      checkOutput("reuse_alu_fun", 32'(alu_fun), 32'd2);
      checkOutput("reuse_alu_a", 32'(alu_a), 32'd5);

      // Bad opcode in IDLE.
      e0 = err_total;
      applyStimulus(8'h7A, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("badop_err", 32'(err), 32'h1);
      checkOutput("badop_busy", 32'(busy), 32'h0);
      waitIdle();
      checkOutput("badop_err_count", 32'(err_total - e0), 32'd1);

      // Bad FUN byte: no execution, operands unchanged.
      e0 = err_total;
      en0 = en_total;
      runFrame(1'b1, 16'd9, 16'd9, 8'h15, 2, 1'b0, 1'b0, 1'b0);
      waitIdle();
      checkOutput("badfun_err_count", 32'(err_total - e0), 32'd1);
      checkOutput("badfun_no_alu_en", 32'(en_total - en0), 32'd0);
      checkOutput("badfun_alu_a", 32'(alu_a), 32'd5);
      checkOutput("badfun_alu_fun", 32'(alu_fun), 32'd2);

      // Back-pressure: tx_busy high for 10 cycles at SEND entry; 0x1234 + 0x0101 = 0x1335.
      n0 = tx_log.size();
      runFrame(1'b1, 16'h1234, 16'h0101, 8'h00, 2, 1'b0, 1'b1, 1'b0);
      fcyc = last_rx_cyc;
      waitIdle();
      checkOutput("bp_byte0", log_byte(n0), 32'h35);
      checkOutput("bp_byte1", log_byte(n0 + 1), 32'h13);
      checkOutput("bp_first_cycle", 32'(log_cyc(n0) - fcyc), 32'd13);
      checkOutput("bp_second_cycle", 32'(log_cyc(n0 + 1) - fcyc), 32'd15);

      // ALU timeout.
      n0 = tx_log.size();
      e0 = err_total;
      en0 = en_total;
      runFrame(1'b0, 16'd0, 16'd0, 8'h00, 5, 1'b0, 1'b0, 1'b0);
      waitIdle();
      checkOutput("timeout_alu_en_cycles", 32'(en_total - en0), 32'd4);
      checkOutput("timeout_err_count", 32'(err_total - e0), 32'd1);
      checkOutput("timeout_no_tx", 32'(tx_log.size() - n0), 32'd0);

      // Byte dropped while sending.
      n0 = tx_log.size();
      e0 = err_total;
      runFrame(1'b0, 16'd0, 16'd0, 8'h01, 2, 1'b1, 1'b0, 1'b0);
      waitIdle();
      checkOutput("drop_err_count", 32'(err_total - e0), 32'd1);
      checkOutput("drop_tx_count", 32'(tx_log.size() - n0), 32'd2);

      // Reset mid-frame, then CC 01 00 01 00 01 -> 00 00.
      applyStimulus(CMD_FULL, 1'b0, 1'b0);
      applyStimulus(8'h05, 1'b0, 1'b0);
      #2;
      RST = 1'b0;
      ma = '0;
      mb = '0;
      mfun = '0;
      exp_alu_en = 1'b0;
      exp_err = 1'b0;
      @(negedge clk);
      checkResetValues("midreset");
      tick();
      RST = 1'b1;
      tick();
      n0 = tx_log.size();
      runFrame(1'b1, 16'd1, 16'd1, 8'h01, 2, 1'b0, 1'b0, 1'b0);
      waitIdle();
      checkOutput("postreset_byte0", log_byte(n0), 32'h00);
      checkOutput("postreset_byte1", log_byte(n0 + 1), 32'h00);
      checkOutput("postreset_alu_a", 32'(alu_a), 32'd1);

      // Randomized frames with random transmitter back-pressure.
      rand_busy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = $urandom_range(0, 99);
         if (kind < 8) begin
            badop = 8'($urandom);
            if (badop == CMD_FULL || badop == CMD_REUSE) badop = 8'h7A;
            applyStimulus(badop, 1'b1, 1'b1);
         end else begin
            logic [7:0] funb;
            int lat;
            funb = ($urandom_range(0, 9) == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)}
                                               : {4'h0, 4'($urandom)};
            lat = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
            runFrame(kind < 65, 16'($urandom), 16'($urandom), funb, lat,
                     $urandom_range(0, 6) == 0, 1'b0, 1'b1);
         end
         waitIdle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
